// File: rtl/calc2_req_master.sv
// Request initiator for one calc2 port: tags each accepted operation, sends it as two
// bus beats and returns the tagged responses in arrival order through a small FIFO.
module calc2_req_master #(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int TAG_W  = 2
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CMD_W-1:0]  op_cmd,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    output logic [TAG_W-1:0]  req_tag_out,
    input  logic [1:0]        out_resp,
    input  logic [DATA_W-1:0] out_data,
    input  logic [TAG_W-1:0]  out_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_resp,
    output logic [DATA_W-1:0] res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              err_spurious
);

    localparam int NUM_TAGS = 2 ** TAG_W;

    typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    state_t              state, state_nxt;
    logic [NUM_TAGS-1:0] busy_mask, inflight_mask;
    logic [TAG_W-1:0]    free_tag;
    logic                any_free;
    logic                accept, issue;
    logic [DATA_W-1:0]   op_b_q;
    logic [CMD_W-1:0]    req_cmd_nxt;
    logic [DATA_W-1:0]   req_data_nxt;
    logic [TAG_W-1:0]    req_tag_nxt;

    entry_t              fifo_mem [NUM_TAGS];
    entry_t              head;
    logic [TAG_W-1:0]    wr_ptr, rd_ptr;
    logic [TAG_W:0]      count;
    logic                push, pop, resp_seen;

    // Lowest-numbered free tag; the busy mask is a tag's lifetime from accept to pop.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        free_tag = '0;
        any_free = ~&busy_mask;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_mask[i]) free_tag = TAG_W'(i);
        end
    end

    // Held low while reset is asserted so nothing is accepted before the masks are clean.
    assign op_ready = reset && (state != SEND1) && any_free;
    assign accept   = op_valid && op_ready;
    assign issue    = accept && (op_cmd != '0);

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state        <= IDLE;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
            op_b_q       <= '0;
        end else begin
            state        <= state_nxt;
            req_cmd_out  <= req_cmd_nxt;
            req_data_out <= req_data_nxt;
            req_tag_out  <= req_tag_nxt;
            if (issue) op_b_q <= op_b;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE, SEND2: state_nxt = issue ? SEND1 : IDLE;
            SEND1:       state_nxt = SEND2;
            default:     state_nxt = IDLE;
        endcase
    end

    // Next bus beat: beat 1 on issue, beat 2 reuses the tag still on the bus from beat 1.
    always_comb begin
        req_cmd_nxt  = '0;
        req_data_nxt = '0;
        req_tag_nxt  = '0;
        if (issue) begin
            req_cmd_nxt  = op_cmd;
            req_data_nxt = op_a;
            req_tag_nxt  = free_tag;
        end else if (state == SEND1) begin
            req_data_nxt = op_b_q;
            req_tag_nxt  = req_tag_out;
        end
    end

    assign resp_seen = (out_resp != 2'd0);
    assign push      = resp_seen && inflight_mask[out_tag];
    assign pop       = res_valid && res_ready;

    // A tag stays busy until its result is popped, so the FIFO can never overflow.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy_mask     <= '0;
            inflight_mask <= '0;
            err_spurious  <= 1'b0;
        end else begin
            if (issue) begin
                busy_mask[free_tag]     <= 1'b1;
                inflight_mask[free_tag] <= 1'b1;
            end
            if (pop)  busy_mask[res_tag]     <= 1'b0;
            if (push) inflight_mask[out_tag] <= 1'b0;
            if (resp_seen && !inflight_mask[out_tag]) err_spurious <= 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the read side is gated by the occupancy count instead.
    always_ff @(posedge c_clk) begin
        if (push) fifo_mem[wr_ptr] <= '{resp: out_resp, data: out_data, tag: out_tag};
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + TAG_W'(1);
            if (pop)  rd_ptr <= rd_ptr + TAG_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (TAG_W + 1)'(1);
                2'b01:   count <= count - (TAG_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign res_valid = (count != '0);
    assign res_resp  = res_valid ? head.resp : '0;
    assign res_data  = res_valid ? head.data : '0;
    assign res_tag   = res_valid ? head.tag  : '0;

endmodule

// File: tb/tb_calc2_req_master.sv
// Randomised scoreboard bench for calc2_req_master with a behavioural calc2 responder.
module tb_calc2_req_master;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int TAG_W  = 2;
    localparam int NT     = 4;

    typedef struct {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } beat_t;

    typedef struct {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    logic              c_clk = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid, op_ready, res_valid, res_ready, err_spurious;
    logic [CMD_W-1:0]  op_cmd, req_cmd_out;
    logic [DATA_W-1:0] op_a, op_b, req_data_out, out_data, res_data;
    logic [TAG_W-1:0]  req_tag_out, out_tag, res_tag;
    logic [1:0]        out_resp, res_resp;

    calc2_req_master #(.DATA_W(DATA_W), .CMD_W(CMD_W), .TAG_W(TAG_W)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_resp(res_resp), .res_data(res_data), .res_tag(res_tag),
        .err_spurious(err_spurious)
    );

    always #5 c_clk = ~c_clk;

    int n_pass  = 0;
    int n_total = 0;

    beat_t       bus_q[$];
    rsp_t        exp_res[$];
    rsp_t        dir_q[$];
    rsp_t        pend_q[$];
    logic [NT-1:0] m_busy, m_inflight;
    logic        exp_err;
    bit          auto_en   = 1'b1;
    int          resp_pct  = 100;
    int          ready_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural calc2: what the real port would answer for a two-beat request.
    function automatic rsp_t calc(input logic [CMD_W-1:0] cmd, input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
        rsp_t r;
        longint unsigned sum;
        int sh;
        sh    = int'(b % DATA_W);
        r.tag = tag;
        case (cmd)
            4'd1: begin
                sum    = longint'(a) + longint'(b);
                r.data = a + b;
                r.resp = (sum > 64'hFFFF_FFFF) ? 2'd2 : 2'd1;
            end
            4'd2: begin r.data = a - b;    r.resp = (b > a) ? 2'd2 : 2'd1; end
            4'd5: begin r.data = a << sh;  r.resp = 2'd1; end
            4'd6: begin r.data = a >> sh;  r.resp = 2'd1; end
            default: begin r.data = '0;    r.resp = 2'd2; end
        endcase
        return r;
    endfunction

    // Scoreboard / reference model, evaluated mid-cycle in a fixed order.
    beat_t eb;
    rsp_t  pr;
    logic  exp_ready, do_pop;
    logic [TAG_W-1:0] pop_tag;
    int    free_t;

    always @(negedge c_clk) begin
        if (!reset) begin
            check("rst_op_ready", op_ready, 0);
            check("rst_req", {req_cmd_out, req_data_out, req_tag_out}, 0);
            check("rst_res", {res_valid, res_resp, res_data, res_tag}, 0);
            check("rst_err", err_spurious, 0);
            bus_q.delete();
            exp_res.delete();
            m_busy = '0; m_inflight = '0; exp_err = 1'b0;
        end else begin
            if (bus_q.size() != 0) eb = bus_q.pop_front();
            else eb = '{cmd: '0, data: '0, tag: '0};
            check("req_cmd", req_cmd_out, eb.cmd);
            check("req_data", req_data_out, eb.data);
            check("req_tag", req_tag_out, eb.tag);
            exp_ready = (bus_q.size() == 0) && (m_busy != '1);
            check("op_ready", op_ready, exp_ready);
            check("res_valid", res_valid, exp_res.size() != 0);
            check("err_spurious", err_spurious, exp_err);

            do_pop = 1'b0;
            if (exp_res.size() != 0 && res_ready) begin
                pr = exp_res.pop_front();
                check("res_resp", res_resp, pr.resp);
                check("res_data", res_data, pr.data);
                check("res_tag", res_tag, pr.tag);
                pop_tag = pr.tag;
                do_pop  = 1'b1;
            end
            if (out_resp != 2'd0) begin
                if (m_inflight[out_tag]) begin
                    exp_res.push_back('{resp: out_resp, data: out_data, tag: out_tag});
                    m_inflight[out_tag] = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (op_valid && exp_ready && op_cmd != '0) begin
                free_t = 0;
                for (int i = NT - 1; i >= 0; i--) if (!m_busy[i]) free_t = i;
                m_busy[free_t]     = 1'b1;
                m_inflight[free_t] = 1'b1;
                bus_q.push_back('{cmd: op_cmd, data: op_a, tag: TAG_W'(free_t)});
                bus_q.push_back('{cmd: '0, data: op_b, tag: TAG_W'(free_t)});
            end
            if (do_pop) m_busy[pop_tag] = 1'b0;
        end
    end

    // calc2 side: watches the bus, builds answers for completed requests.
    logic              have_b1;
    logic [CMD_W-1:0]  b1_cmd;
    logic [DATA_W-1:0] b1_a;
    logic [TAG_W-1:0]  b1_tag;

    always @(negedge c_clk) begin
        if (!reset) begin
            pend_q.delete();
            have_b1 = 1'b0;
        end else if (have_b1) begin
            have_b1 = 1'b0;
            if (auto_en) pend_q.push_back(calc(b1_cmd, b1_a, req_data_out, b1_tag));
        end else if (req_cmd_out != '0) begin
            have_b1 = 1'b1;
            b1_cmd  = req_cmd_out;
            b1_a    = req_data_out;
            b1_tag  = req_tag_out;
        end
    end

    // Single driver of the response bus: directed entries first, else a random pending answer.
    rsp_t dr;
    int   pick;
    initial begin
        out_resp = '0; out_data = '0; out_tag = '0;
        forever begin
            @(posedge c_clk); #1;
            dr = '{resp: '0, data: '0, tag: '0};
            if (dir_q.size() != 0) begin
                dr = dir_q.pop_front();
            end else if (auto_en && pend_q.size() != 0 && $urandom_range(99) < resp_pct) begin
                pick = $urandom_range(pend_q.size() - 1);
                dr   = pend_q[pick];
                pend_q.delete(pick);
            end
            out_resp = dr.resp; out_data = dr.data; out_tag = dr.tag;
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge c_clk); #1;
            res_ready = ($urandom_range(99) < ready_pct);
        end
    end

    task automatic issue(input logic [CMD_W-1:0] cmd, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b);
        bit got;
        got = 1'b0;
        op_valid = 1'b1; op_cmd = cmd; op_a = a; op_b = b;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge c_clk);
            got = op_ready;
        end
        check("issue_accepted", got, 1);
        @(posedge c_clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge c_clk);
            done = (m_busy == '0) && (bus_q.size() == 0) && (dir_q.size() == 0);
        end
        check("drain_done", done, 1);
        @(posedge c_clk); #1;
    endtask

    function automatic logic [CMD_W-1:0] rand_cmd();
        logic [CMD_W-1:0] cmds [6];
        cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd0, 4'd3};
        return cmds[$urandom_range(5)];
    endfunction

    initial begin
        bit seen;
        op_valid = 1'b0; op_cmd = '0; op_a = '0; op_b = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge c_clk);
        #1 reset = 1'b1;
        @(negedge c_clk);
        check("op_ready_after_reset", op_ready, 1);
        @(posedge c_clk); #1;

        // add 5+3 then reuse of tag 0
        issue(4'd1, 32'd5, 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge c_clk);
            seen = res_valid;
        end
        check("add_res_seen", seen, 1);
        check("add_res_data", res_data, 8);
        check("add_res_tag", res_tag, 0);
        check("add_res_resp", res_resp, 1);
        drain();
        issue(4'd1, 32'd7, 32'd9);
        drain();

        // four ops fill all tags, fifth waits for the first pop
        ready_pct = 0;
        fork begin repeat (25) @(posedge c_clk); ready_pct = 100; end join_none
        for (int i = 0; i < 5; i++) issue(4'd1, $urandom, $urandom);
        drain();

        // responses out of tag order come back in arrival order
        auto_en = 1'b0; ready_pct = 0;
        for (int i = 0; i < 3; i++) issue(4'd2, 32'd100 + i, 32'd1);
        repeat (3) @(posedge c_clk);
        dir_q.push_back('{resp: 2'd1, data: 32'hA, tag: 2'd2});
        dir_q.push_back('{resp: 2'd1, data: 32'hB, tag: 2'd0});
        dir_q.push_back('{resp: 2'd1, data: 32'hC, tag: 2'd1});
        repeat (8) @(posedge c_clk);
        #1 ready_pct = 100;
        drain();

        // null command is consumed without a tag
        auto_en = 1'b1;
        issue(4'd0, 32'd1, 32'd2);
        issue(4'd1, 32'd10, 32'd20);
        drain();

        // random traffic
        resp_pct = 30; ready_pct = 60;
        for (int i = 0; i < 60; i++) issue(rand_cmd(), $urandom, $urandom);
        resp_pct = 100; ready_pct = 100;
        drain();

        // spurious response while idle; flag is sticky
        dir_q.push_back('{resp: 2'd2, data: 32'h0, tag: 2'd3});
        repeat (6) @(posedge c_clk);
        #1;
        check("spurious_flag", err_spurious, 1);
        check("spurious_no_result", res_valid, 0);

        // reset during beat 1
        issue(4'd1, 32'd100, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_req_cmd", req_cmd_out, 0);
        check("midrst_req_data", req_data_out, 0);
        check("midrst_op_ready", op_ready, 0);
        check("midrst_err", err_spurious, 0);
        @(negedge c_clk);
        @(posedge c_clk); #1 reset = 1'b1;
        dir_q.push_back('{resp: 2'd1, data: 32'h55, tag: 2'd0});
        repeat (4) @(posedge c_clk);
        #1;
        check("late_resp_spurious", err_spurious, 1);
        issue(4'd1, 32'd4, 32'd4);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/calc2_req_master.md
# calc2_req_master

Synthesizable request initiator for one calc2 port: accepts operations on a valid/ready interface, allocates a free tag, and serialises each operation onto the two-beat calc2 request bus. It collects tagged responses from the same port and returns them in arrival order. One instance sits between a local operation source and each `reqN_*`/`out_*N` port pair of `calc2_top`, replacing the bench driver in system-level builds.

## Interface
- `DATA_W`, 32, operand/result width
- `CMD_W`, 4, calc2 command width
- `TAG_W`, 2, tag width; NUM_TAGS = 2**TAG_W outstanding max
- `c_clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  operation offered
- `op_ready`  out  1  operation accepted when `op_valid & op_ready`
- `op_cmd`  in  CMD_W  calc2 command (1 add, 2 sub, 5 shl, 6 shr; others passed verbatim)
- `op_a`, `op_b`  in  DATA_W  operand 1, operand 2
- `req_cmd_out`  out  CMD_W  to calc2 `reqN_cmd_in`
- `req_data_out`  out  DATA_W  to calc2 `reqN_data_in`
- `req_tag_out`  out  TAG_W  to calc2 `reqN_tag_in`
- `out_resp`  in  2  from calc2 (0 none, 1 ok, 2 overflow/underflow/invalid)
- `out_data`  in  DATA_W  from calc2
- `out_tag`  in  TAG_W  from calc2
- `res_valid`  out  1  result available (result FIFO non-empty)
- `res_ready`  in  1  result consumed when `res_valid & res_ready`
- `res_resp`, `res_data`, `res_tag`  out  2 / DATA_W / TAG_W  head-of-FIFO result
- `err_spurious`  out  1  sticky: response received for a tag not in flight

## Operation
- Issue FSM states: IDLE, SEND1, SEND2. All `req_*` outputs registered.
- IDLE/SEND2: `op_ready` = any bit clear in `busy_mask`. On accept with `op_cmd` ≠ 0 → SEND1; allocate lowest-numbered free tag t; set `busy_mask[t]`, `inflight_mask[t]`.
- SEND1: drive `req_cmd_out`=op_cmd, `req_data_out`=op_a, `req_tag_out`=t; `op_ready`=0; → SEND2.
- SEND2: drive `req_cmd_out`=0, `req_data_out`=op_b, `req_tag_out`=t; → SEND1 if new op accepted this cycle, else IDLE.
- IDLE: `req_cmd_out`=0, `req_data_out`=0, `req_tag_out`=0.
- `op_cmd`=0: handshake completes, op dropped, no tag allocated, no bus activity, FSM → IDLE.
- Response capture: when `out_resp` ≠ 0 at edge and `inflight_mask[out_tag]`=1 → push {resp,data,tag} into NUM_TAGS-deep FIFO, clear `inflight_mask[out_tag]`. If bit clear → discard, set `err_spurious`.
- Result pop clears `busy_mask[res_tag]`. Tag reusable only after pop, so FIFO can never overflow; no response is dropped.
- Allocation uses registered `busy_mask`: a tag freed by a pop is allocatable from the next cycle.
- Push and pop in same cycle: occupancy unchanged; empty FIFO is not bypassed (push visible next cycle).

## Timing
- Accept in cycle N → beat 1 on bus in N+1, beat 2 in N+2; next accept allowed in N+2 → back-to-back two-cycle slots with no gap.
- Response sampled in cycle M → `res_valid`=1 in M+1 (FIFO show-ahead).
- Pop in cycle P → tag free, `op_ready` may rise, in P+1.
- Reset (asynchronous, active-low): FSM IDLE, masks 0, FIFO empty, `req_cmd_out`=0, `req_data_out`=0, `req_tag_out`=0, `res_valid`=0, `res_*`=0, `err_spurious`=0; `op_ready`=0 while reset asserted, 1 from first cycle after release.
- Reset mid-operation: partial request abandoned immediately; responses arriving after release flagged spurious.
- `err_spurious` cleared only by reset.

## Test plan
- Reset release, op add 5+3: bus shows cmd=1/data=5/tag=0 then cmd=0/data=3/tag=0; model returns resp=1 data=8 tag=0 → next cycle `res_valid`=1, res_data=8, res_tag=0; after pop tag 0 reallocated.
- Four ops offered continuously: tags 0,1,2,3 on consecutive two-cycle slots, no idle cycle; fifth op sees `op_ready`=0 until first pop, then gets the popped tag.
- Ops on tags 0,1,2; responses returned tag 2 (data 0xA), tag 0 (0xB), tag 1 (0xC) → results popped in order 2,0,1 with matching data.
- Response resp=2 tag=3 while idle → `err_spurious`=1, `res_valid` stays 0; flag holds until reset.
- op_cmd=0 offered → accepted in one cycle, bus stays cmd=0, `busy_mask` unchanged, following add uses tag 0.
- Reset asserted during SEND1 → `req_*` go 0 without clock edge, `op_ready`=0; after release all four tags free and first op gets tag 0.
